// File: rtl/regfile_alu_core.sv
// rtl/regfile_alu_core.sv - 16x32 register file with combinational 13-op ALU and registered compare flags
module regfile_alu_core #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int SW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr1,
    output logic [WIDTH-1:0] rd_data1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data2,
    input  logic [12:0]      alu_op,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_result,
    output logic             flag_gt,
    output logic             flag_et
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data1 = regs[rd_addr1];
    assign rd_data2 = regs[rd_addr2];

    // Division runs on magnitudes so MIN / -1 wraps naturally instead of overflowing.
    logic [WIDTH-1:0] abs_a, abs_b, div_den, uquo, urem, quo, rem;
    logic [SW-1:0]    shamt;

    assign abs_a   = alu_a[WIDTH-1] ? -alu_a : alu_a;
    assign abs_b   = alu_b[WIDTH-1] ? -alu_b : alu_b;
    assign div_den = (alu_b == '0) ? ONE : abs_b;
    assign uquo    = abs_a / div_den;
    assign urem    = abs_a % div_den;
    assign shamt   = alu_b[SW-1:0];

    always_comb begin
        quo = (alu_a[WIDTH-1] ^ alu_b[WIDTH-1]) ? -uquo : uquo;
        rem = alu_a[WIDTH-1] ? -urem : urem;
        if (alu_b == '0) begin
            quo = '1;
            rem = alu_a;
        end
    end

    // Lowest set bit of alu_op wins.
    always_comb begin
        alu_result = '0;
        if      (alu_op[0])  alu_result = alu_a + alu_b;
        else if (alu_op[1])  alu_result = alu_a - alu_b;
        else if (alu_op[2])  alu_result = '0;
        else if (alu_op[3])  alu_result = alu_a * alu_b;
        else if (alu_op[4])  alu_result = quo;
        else if (alu_op[5])  alu_result = rem;
        else if (alu_op[6])  alu_result = alu_a << shamt;
        else if (alu_op[7])  alu_result = alu_a >> shamt;
        else if (alu_op[8])  alu_result = $unsigned($signed(alu_a) >>> shamt);
        else if (alu_op[9])  alu_result = alu_a | alu_b;
        else if (alu_op[10]) alu_result = alu_a & alu_b;
        else if (alu_op[11]) alu_result = ~alu_b;
        else if (alu_op[12]) alu_result = alu_b;
    end

    logic cmp_sel;
    assign cmp_sel = alu_op[2] & ~alu_op[1] & ~alu_op[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_gt <= 1'b0;
            flag_et <= 1'b0;
        end else if (cmp_sel) begin
            flag_gt <= $signed(alu_a) > $signed(alu_b);
            flag_et <= alu_a == alu_b;
        end
    end

endmodule

// File: tb/tb_regfile_alu_core.sv
// tb/tb_regfile_alu_core.sv - scoreboard bench for regfile_alu_core
module tb_regfile_alu_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  rd_addr1 = '0;
    logic [31:0] rd_data1;
    logic [3:0]  rd_addr2 = '0;
    logic [31:0] rd_data2;
    logic [12:0] alu_op = '0;
    logic [31:0] alu_a = '0;
    logic [31:0] alu_b = '0;
    logic [31:0] alu_result;
    logic        flag_gt, flag_et;

    regfile_alu_core #(.WIDTH(32), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .flag_gt(flag_gt), .flag_et(flag_et)
    );

    always #5 clk = ~clk;

    localparam int K_RD1 = 0, K_RD2 = 1, K_ALU = 2, K_GT = 3, K_ET = 4;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.kind)
                    K_RD1:   act = rd_data1;
                    K_RD2:   act = rd_data2;
                    K_ALU:   act = alu_result;
                    K_GT:    act = {31'b0, flag_gt};
                    default: act = {31'b0, flag_et};
                endcase
                n_cmp++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic sample();
        -> sample_ev;
        #2;
    endtask

    task automatic expect_flags(input logic gt, input logic et, input string name);
        expect_val(K_GT, {31'b0, gt}, {name, "_gt"});
        expect_val(K_ET, {31'b0, et}, {name, "_et"});
    endtask

    typedef struct {
        int          bitn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, "add_wrap"},
            '{1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, "sub_neg"},
            '{3,  32'hFFFFFFFD, 32'h00000004, 32'hFFFFFFF4, "mul_neg"},
            '{4,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, "div_neg"},
            '{4,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, "div_negb"},
            '{5,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, "mod_neg"},
            '{5,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, "mod_negb"},
            '{4,  32'h00000009, 32'h00000000, 32'hFFFFFFFF, "div_zero"},
            '{5,  32'h00000009, 32'h00000000, 32'h00000009, "mod_zero"},
            '{4,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf"},
            '{5,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, "mod_ovf"},
            '{6,  32'h80000010, 32'h00000004, 32'h00000100, "lsl"},
            '{7,  32'h80000010, 32'h00000004, 32'h08000001, "lsr"},
            '{8,  32'h80000010, 32'h00000004, 32'hF8000001, "asr"},
            '{9,  32'h000000F0, 32'h0000000F, 32'h000000FF, "or"},
            '{10, 32'h000000F0, 32'h0000003C, 32'h00000030, "and"},
            '{11, 32'h80000010, 32'h0F0F0F0F, 32'hF0F0F0F0, "not"},
            '{12, 32'h80000010, 32'h00000004, 32'h00000004, "mov"},
            '{6,  32'h80000010, 32'h00000024, 32'h00000100, "lsl_wide_b"}
        };
    end

    initial begin
        @(posedge clk);
        #1;
        rd_addr1 = 4'd0;
        rd_addr2 = 4'd15;
        expect_val(K_RD1, 32'h0, "reset_r0");
        expect_val(K_RD2, 32'h0, "reset_r15");
        expect_flags(1'b0, 1'b0, "reset");
        sample();
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = 32'hA5000000 + 32'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i);
            rd_addr2 = 4'(15 - i);
            expect_val(K_RD1, 32'hA5000000 + 32'(i), $sformatf("rd1_r%0d", i));
            expect_val(K_RD2, 32'hA5000000 + 32'(15 - i), $sformatf("rd2_r%0d", 15 - i));
            sample();
        end

        @(negedge clk);
        wr_en    = 1'b1;
        wr_addr  = 4'd7;
        wr_data  = 32'h55;
        rd_addr1 = 4'd7;
        expect_val(K_RD1, 32'hA5000007, "rdw_before");
        sample();
        @(negedge clk);
        wr_en = 1'b0;
        expect_val(K_RD1, 32'h00000055, "rdw_after");
        sample();
        n_cmp++;
        if (rd_data1 !== 32'h00000055) begin
            n_fail++;
            $display("FAIL rdw_after_direct: got %h expected %h", rd_data1, 32'h00000055);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            alu_op = 13'(1) << vecs[i].bitn;
            alu_a  = vecs[i].a;
            alu_b  = vecs[i].b;
            expect_val(K_ALU, vecs[i].exp, vecs[i].name);
            sample();
        end

        @(negedge clk);
        alu_op = 13'h004; alu_a = 32'd5; alu_b = 32'hFFFFFFFF;
        expect_val(K_ALU, 32'h0, "cmp_result");
        sample();
        @(negedge clk);
        alu_op = 13'h004; alu_a = 32'd7; alu_b = 32'd7;
        expect_flags(1'b1, 1'b0, "cmp_5_m1");
        sample();
        @(negedge clk);
        alu_op = 13'h001; alu_a = 32'd1; alu_b = 32'd2;
        expect_flags(1'b0, 1'b1, "cmp_7_7");
        sample();
        @(negedge clk);
        alu_op = 13'h000; alu_a = 32'd9; alu_b = 32'd3;
        expect_flags(1'b0, 1'b1, "add_hold");
        expect_val(K_ALU, 32'h0, "noop_result");
        sample();
        @(negedge clk);
        alu_op = 13'h004; alu_a = 32'hFFFFFFFE; alu_b = 32'd3;
        expect_flags(1'b0, 1'b1, "noop_hold");
        sample();
        @(negedge clk);
        alu_op = 13'h006; alu_a = 32'd10; alu_b = 32'd3;
        expect_flags(1'b0, 1'b0, "cmp_m2_3");
        expect_val(K_ALU, 32'd7, "prio_sub");
        sample();
        n_cmp++;
        if (alu_result !== 32'd7) begin
            n_fail++;
            $display("FAIL prio_sub_direct: got %h expected %h", alu_result, 32'd7);
        end
        @(negedge clk);
        alu_op = 13'h000;
        expect_flags(1'b0, 1'b0, "prio_no_cmp");
        sample();

        @(negedge clk);
        alu_op = 13'h004; alu_a = 32'd7; alu_b = 32'd7;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h1234;
        @(negedge clk);
        wr_en = 1'b0; alu_op = 13'h000;
        rd_addr1 = 4'd3; rd_addr2 = 4'd5;
        expect_val(K_RD1, 32'h1234, "pre_reset_r3");
        expect_val(K_ET, 32'h1, "pre_reset_et");
        sample();
        rst = 1'b0;
        expect_val(K_RD1, 32'h0, "async_reset_r3");
        expect_val(K_RD2, 32'h0, "async_reset_r5");
        expect_flags(1'b0, 1'b0, "async_reset");
        sample();
        n_cmp++;
        if (rd_data2 !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_r5_direct: got %h expected %h", rd_data2, 32'h0);
        end
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hBEEF;
        @(negedge clk);
        wr_en = 1'b0;
        rst   = 1'b1;
        expect_val(K_RD1, 32'h0, "reset_beats_write");
        sample();

        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/regfile_alu_core.md
# regfile_alu_core

Combined register file and integer ALU for the 16-bit-opcode RISC datapath. It holds the 16×32 general-purpose register file, with two asynchronous read ports and one synchronous write port. It also holds a combinational 13-operation ALU and a registered GT/ET flag pair that is written by compare. It sits between instruction decode (register addresses, operand mux) and writeback/branch logic (result, flags).

## Interface
Parameters:
- WIDTH, 32: data width of registers and ALU operands.
- DEPTH, 16: number of registers. Address width is 4.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- wr_en  in  1  register write enable.
- wr_addr  in  4  write register index.
- wr_data  in  32  write data.
- rd_addr1  in  4  read port 1 index.
- rd_data1  out  32  read port 1 data.
- rd_addr2  in  4  read port 2 index.
- rd_data2  out  32  read port 2 data.
- alu_op  in  13  one-hot operation select. Bit 0 is the lowest bit. Order: [0]add [1]sub [2]cmp [3]mul [4]div [5]mod [6]lsl [7]lsr [8]asr [9]or [10]and [11]not [12]mov.
- alu_a  in  32  operand A (op1).
- alu_b  in  32  operand B (op2, register or immediate, selected upstream).
- alu_result  out  32  combinational ALU result.
- flag_gt  out  1  registered "A greater than B" from the last cmp.
- flag_et  out  1  registered "A equal to B" from the last cmp.

## Operation
- Register file: 16 × 32-bit registers. All are general purpose; r15 (return address) has no special handling here.
- Reads are combinational: rd_dataN = reg[rd_addrN]. Both ports are independent, and the same address on both ports is legal.
- Write: when wr_en=1, reg[wr_addr] ← wr_data at the clk rising edge.
- Read-during-write to the same address returns the old value until the edge. There is no bypass.
- ALU result is combinational from alu_a, alu_b and alu_op. All operands are 32-bit two's complement.
- add: A+B, mod 2^32.
- sub: A−B, mod 2^32.
- cmp: result 0.
- mul: low 32 bits of the signed product.
- div: signed quotient, truncated toward zero.
- mod: signed remainder; the sign follows A.
- div by B=0 gives 0xFFFFFFFF; mod by B=0 gives A.
- 0x80000000 / −1 gives 0x80000000; 0x80000000 mod −1 gives 0.
- lsl: A << B[4:0].
- lsr: logical A >> B[4:0].
- asr: arithmetic A >>> B[4:0].
- or: A|B.
- and: A&B.
- not: ~B.
- mov: B.
- If alu_op is zero, alu_result = 0.
- If more than one bit is set, the lowest-index set bit wins. This is a fixed priority, not an error.
- Flags: on a rising edge with alu_op[2]=1 (cmp selected after the priority rule), the flags load as follows:
  - flag_gt ← signed(A) > signed(B).
  - flag_et ← (A == B).
- On any edge without cmp, the flags hold. No other operation modifies the flags.

## Timing
- Reset (rst=0, asynchronous): all 16 registers become 0 and flag_gt = flag_et = 0 immediately. rd_data then reflects 0 combinationally, and alu_result follows its inputs.
- Write latency is one edge. A value written at edge N is visible on the read ports right after edge N.
- A reset asserted while wr_en=1 wins; the write is discarded.
- Reset deassertion has no effect until the next rising edge.
- ALU latency is zero cycles; alu_result is purely combinational.
- Flag latency is one edge. The flags become visible after the edge on which cmp was presented.
- There is no handshake or stall; every input is sampled every cycle.

## Test plan
- Reset then read: assert rst=0 mid-cycle after writing r3=0x1234. r3 reads 0 immediately, and both flags read 0.
- Write/read all registers: write reg i = 0xA5000000+i for i=0..15. Both read ports return the matching values. Read r7 while writing r7=0x55 in the same cycle: the old value appears before the edge and 0x55 after.
- Arithmetic:
  - add 0xFFFFFFFF+1 → 0.
  - sub 5−7 → 0xFFFFFFFE.
  - mul −3×4 → 0xFFFFFFF4.
  - div −7/2 → 0xFFFFFFFD.
  - mod −7,2 → 0xFFFFFFFF.
  - div 9/0 → 0xFFFFFFFF.
  - mod 9,0 → 9.
- Shifts/logic, with A=0x80000010 and B=4:
  - lsl → 0x00000100.
  - lsr → 0x08000001.
  - asr → 0xF8000001.
  - not with B=0x0F0F0F0F → 0xF0F0F0F0.
  - mov with B=4 → 4.
  - lsl with B=0x24 → A<<4.
- Compare:
  - cmp A=5, B=−1: after the edge GT=1, ET=0, and alu_result=0.
  - cmp 7,7: GT=0, ET=1.
  - A following add cycle leaves the flags unchanged.
  - cmp −2,3: GT=0, ET=0.
- Priority/no-op:
  - alu_op=0 → result 0, flags held.
  - alu_op with bits 1 and 2 set → sub result, flags unchanged.
